addsub_seq_ctrl: RTL and testbench
==================================

ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles each digit stays selected during display scan (legal range 2..2^20).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  4  unsigned operand A (switches, stable while start asserted).
REQ-005 b  input  4  unsigned operand B.
REQ-006 sum_rest  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-007 start  input  1  synchronous single-cycle request to capture operands and compute.
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  one-cycle pulse when a new result reaches the display.
REQ-010 segm  output  7  active-low segments, segm[0]=a ... segm[6]=g.
REQ-011 transistor  output  4  active-low digit enables, transistor[i]=0 selects digit i.

Function
REQ-012 FSM states IDLE, CALC, CONV, SHOW; reset state IDLE.
REQ-013 Edge with start=1 in IDLE or SHOW: register a, b, sum_rest; go to CALC.
REQ-014 start in CALC or CONV ignored; no capture, no state change.
REQ-015 CALC -> CONV unconditionally: 6-bit signed result = A+B (0..30) or A-B (-15..15), operands zero-extended.
REQ-016 CONV -> SHOW unconditionally: latch display set {op, sign, tens, units}; magnitude = |result|, tens = magnitude/10, units = magnitude mod 10.
REQ-017 busy = 1 exactly in CALC and CONV; 0 otherwise.
REQ-018 done = 1 for exactly the first cycle in SHOW after each CONV; latency start edge -> done high = 3 edges.
REQ-019 SHOW holds until next accepted start; new display set replaces old only on CONV -> SHOW edge (old result displayed during CALC/CONV).
REQ-020 Digit map: digit3 = op ('A' add, '5' sub); digit2 = '-' if result negative else blank; digit1 = tens, blank if tens = 0; digit0 = units (always shown, incl. 0).
REQ-021 Active-low codes (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, minus=0111111, blank=1111111.
REQ-022 Scan: prescaler counts 0..REFRESH_DIV-1 then wraps; on wrap digit index advances 0->1->2->3->0.
REQ-023 Exactly one transistor bit low at any time once a result exists; segm is the code for the selected digit in the same cycle (no skew between segm and transistor).
REQ-024 Before first valid result since reset: transistor = 4'b1111, segm = 7'b1111111; prescaler and digit index still run.
REQ-025 Scanning never stalls during CALC/CONV or on start.

Reset
REQ-026 rst_n low asynchronously forces: state IDLE, busy 0, done 0, segm 7'b1111111, transistor 4'b1111, prescaler 0, digit index 0, operand/result/display registers 0, result-valid flag 0.
REQ-027 rst_n low mid-CALC/CONV aborts computation; no done pulse after release.
REQ-028 Operation resumes on first rising clk edge after rst_n deasserts; start on that edge is accepted.

Verification
REQ-029 REFRESH_DIV=4; a=9, b=5, sum_rest=0, pulse start -> busy high 2 cycles, done pulse 3rd cycle; scan digit0..3 = '4','1',blank,'A' (0011001,1111001,1111111,0001000), each for 4 cycles.
REQ-030 a=3, b=7, sum_rest=1 -> result -4: digit3 '5' 0010010, digit2 minus 0111111, digit1 blank, digit0 '4' 0011001.
REQ-031 a=15, b=15, add -> 30: digits '0','3', blank, 'A'; then a=15, b=15, sub -> 0: digit0 '0' 1000000, digit1 and digit2 blank, digit3 '5'.
REQ-032 start held high 5 cycles from IDLE -> captured at first edge, ignored in CALC/CONV, re-captured in SHOW (second done pulse 3 edges later); done never high 2 consecutive cycles.
REQ-033 Assert rst_n low during CONV -> outputs immediately blank/1111, no done pulse; after release without start display stays blank while scan counters run.
REQ-034 Over 16*REFRESH_DIV cycles with valid result: transistor always one-hot-low, each digit selected exactly REFRESH_DIV consecutive cycles, order 0,1,2,3 wraps.

Source files
------------

// File: rtl/addsub_seq_ctrl_if.sv
// Operand/handshake/display bundle for the add/subtract sequencer.
// master = operator side (switches, start button, display sink); slave = the sequencer.
interface addsub_seq_ctrl_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       sum_rest;
  logic       start;
  logic       busy;
  logic       done;
  logic [6:0] segm;
  logic [3:0] transistor;

  modport master (
    output a, b, sum_rest, start,
    input  busy, done, segm, transistor
  );

  modport slave (
    input  a, b, sum_rest, start,
    output busy, done, segm, transistor
  );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// 4-bit add/subtract sequencer: capture, compute, BCD-convert, then show the result
// on a 4-digit multiplexed active-low 7-segment display.
module addsub_seq_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic               clk,
  input logic               rst_n,
  addsub_seq_ctrl_if.slave  bus
);

  localparam int unsigned    PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_5     = 7'b0010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2,
    SHOW = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic        op_q, op_d;
  logic [5:0]  res_q, res_d;
  logic        disp_op_q, disp_op_d;
  logic        disp_neg_q, disp_neg_d;
  logic [1:0]  disp_tens_q, disp_tens_d;
  logic [3:0]  disp_units_q, disp_units_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]  digit_q, digit_d;

  logic [5:0]  mag;
  logic [5:0]  rem;
  logic [1:0]  tens;
  logic [6:0]  seg_sel;

  function automatic logic [6:0] seg_dec(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Magnitude is at most 30, so a compare chain replaces a divider.
  always_comb begin
    mag  = res_q[5] ? (~res_q + 6'd1) : res_q;
    tens = 2'd0;
    rem  = mag;
    if (mag >= 6'd30) begin
      tens = 2'd3;
      rem  = mag - 6'd30;
    end else if (mag >= 6'd20) begin
      tens = 2'd2;
      rem  = mag - 6'd20;
    end else if (mag >= 6'd10) begin
      tens = 2'd1;
      rem  = mag - 6'd10;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    res_d        = res_q;
    disp_op_d    = disp_op_q;
    disp_neg_d   = disp_neg_q;
    disp_tens_d  = disp_tens_q;
    disp_units_d = disp_units_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE, SHOW: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.sum_rest;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = op_q ? ({2'b00, a_q} - {2'b00, b_q})
                       : ({2'b00, a_q} + {2'b00, b_q});
        state_d = CONV;
      end
      CONV: begin
        disp_op_d    = op_q;
        disp_neg_d   = res_q[5];
        disp_tens_d  = tens;
        disp_units_d = rem[3:0];
        valid_d      = 1'b1;
        done_d       = 1'b1;
        state_d      = SHOW;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan runs independently of the FSM so the display never freezes mid-computation.
  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      res_q        <= '0;
      disp_op_q    <= 1'b0;
      disp_neg_q   <= 1'b0;
      disp_tens_q  <= '0;
      disp_units_q <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      presc_q      <= '0;
      digit_q      <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      res_q        <= res_d;
      disp_op_q    <= disp_op_d;
      disp_neg_q   <= disp_neg_d;
      disp_tens_q  <= disp_tens_d;
      disp_units_q <= disp_units_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      presc_q      <= presc_d;
      digit_q      <= digit_d;
    end
  end

  // segm and transistor derive from the same registers, so they never skew.
  always_comb begin
    case (digit_q)
      2'd0:    seg_sel = seg_dec(disp_units_q);
      2'd1:    seg_sel = (disp_tens_q == 2'd0) ? SEG_BLANK : seg_dec({2'b00, disp_tens_q});
      2'd2:    seg_sel = disp_neg_q ? SEG_MINUS : SEG_BLANK;
      default: seg_sel = disp_op_q ? SEG_5 : SEG_A;
    endcase
  end

  assign bus.segm       = valid_q ? seg_sel : SEG_BLANK;
  assign bus.transistor = valid_q ? ~(4'b0001 << digit_q) : 4'b1111;
  assign bus.busy       = (state_q == CALC) || (state_q == CONV);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl: vector table, scoreboard queue,
// and hand-written sequences for held start, reset abort and scan timing.
module tb_addsub_seq_ctrl;
  localparam int unsigned RD = 4;

  typedef struct packed {
    logic [3:0]      a;
    logic [3:0]      b;
    logic            op;
    logic [3:0][6:0] seg;   // seg[3]=op digit ... seg[0]=units
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_seq_ctrl_if bus ();

  addsub_seq_ctrl #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sel_digit(input logic [3:0] t);
    case (t)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // One full scan rotation; compares each digit's code and counts extra done pulses.
  task automatic scan_check(input vec_t v);
    logic [6:0] got[4];
    bit         seen[4];
    int         bad_sel = 0;
    int         extra_done = 0;
    int         d;
    for (int unsigned k = 0; k < 4; k++) begin
      seen[k] = 1'b0;
      got[k]  = 7'h00;
    end
    repeat (4 * RD) begin
      @(negedge clk);
      d = sel_digit(bus.transistor);
      if (d < 0) bad_sel++;
      else begin
        got[d]  = bus.segm;
        seen[d] = 1'b1;
      end
      if (bus.done) extra_done++;
    end
    check("scan_onehot", bad_sel, 0);
    check("done_single", extra_done, 0);
    for (int unsigned k = 0; k < 4; k++) begin
      check($sformatf("digit%0d_seen", k), {31'b0, seen[k]}, 1);
      check($sformatf("digit%0d_seg a=%0d b=%0d op=%0d", k, v.a, v.b, v.op), {25'b0, got[k]}, {25'b0, v.seg[k]});
    end
  endtask

  task automatic check_old(input vec_t prev);
    int d;
    d = sel_digit(bus.transistor);
    check("old_disp_sel", {31'b0, d >= 0}, 1);
    if (d >= 0) check("old_disp_seg", {25'b0, bus.segm}, {25'b0, prev.seg[d]});
  endtask

  // Called at a falling edge: pulses start for one rising edge and follows the result through.
  task automatic pulse(input vec_t v, input bit have_prev, input vec_t prev);
    vec_t e;
    bus.a = v.a;
    bus.b = v.b;
    bus.sum_rest = v.op;
    bus.start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_calc", {31'b0, bus.busy}, 1);
    check("done_calc", {31'b0, bus.done}, 0);
    if (have_prev) check_old(prev);
    @(negedge clk);
    check("busy_conv", {31'b0, bus.busy}, 1);
    check("done_conv", {31'b0, bus.done}, 0);
    if (have_prev) check_old(prev);
    @(negedge clk);
    check("done_latency", {31'b0, bus.done}, 1);
    check("busy_show", {31'b0, bus.busy}, 0);
    check("sb_nonempty", {31'b0, sb.size() != 0}, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      scan_check(e);
    end
  endtask

  initial begin
    bit   exp_d[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit   exp_b[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit   prev_done;
    int   dbl;
    int   bad;
    int   cur, run, d;
    bit   first;
    vec_t e;

    tbl[0] = '{4'd9,  4'd5,  1'b0, {7'b0001000, 7'b1111111, 7'b1111001, 7'b0011001}}; // 14
    tbl[1] = '{4'd3,  4'd7,  1'b1, {7'b0010010, 7'b0111111, 7'b1111111, 7'b0011001}}; // -4
    tbl[2] = '{4'd15, 4'd15, 1'b0, {7'b0001000, 7'b1111111, 7'b0110000, 7'b1000000}}; // 30
    tbl[3] = '{4'd15, 4'd15, 1'b1, {7'b0010010, 7'b1111111, 7'b1111111, 7'b1000000}}; // 0
    tbl[4] = '{4'd0,  4'd15, 1'b1, {7'b0010010, 7'b0111111, 7'b1111001, 7'b0010010}}; // -15
    tbl[5] = '{4'd7,  4'd3,  1'b0, {7'b0001000, 7'b1111111, 7'b1111001, 7'b1000000}}; // 10
    tbl[6] = '{4'd12, 4'd4,  1'b1, {7'b0010010, 7'b1111111, 7'b1111111, 7'b0000000}}; // 8
    tbl[7] = '{4'd6,  4'd0,  1'b0, {7'b0001000, 7'b1111111, 7'b1111111, 7'b0000010}}; // 6
    tbl[8] = '{4'd13, 4'd9,  1'b0, {7'b0001000, 7'b1111111, 7'b0100100, 7'b0100100}}; // 22
    tbl[9] = '{4'd2,  4'd9,  1'b1, {7'b0010010, 7'b0111111, 7'b1111111, 7'b1111000}}; // -7

    bus.a = '0;
    bus.b = '0;
    bus.sum_rest = 1'b0;
    bus.start = 1'b0;

    #12;
    check("rst_transistor", {28'b0, bus.transistor}, 32'hF);
    check("rst_segm", {25'b0, bus.segm}, 32'h7F);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_done", {31'b0, bus.done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    repeat (2 * RD) begin
      @(negedge clk);
      if (bus.transistor !== 4'hF || bus.segm !== 7'h7F || bus.busy || bus.done) bad++;
    end
    check("no_result_blank", bad, 0);

    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      pulse(tbl[i], i > 0, (i > 0) ? tbl[i-1] : tbl[0]);
    end

    // start held for five rising edges: captured, ignored twice, captured again
    @(negedge clk);
    bus.a = tbl[0].a;
    bus.b = tbl[0].b;
    bus.sum_rest = tbl[0].op;
    bus.start = 1'b1;
    sb.push_back(tbl[0]);
    sb.push_back(tbl[0]);
    prev_done = 1'b0;
    dbl = 0;
    e = tbl[0];
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 4) bus.start = 1'b0;
      check($sformatf("held_done%0d", k + 1), {31'b0, bus.done}, {31'b0, exp_d[k]});
      check($sformatf("held_busy%0d", k + 1), {31'b0, bus.busy}, {31'b0, exp_b[k]});
      if (bus.done && prev_done) dbl++;
      prev_done = bus.done;
      if (bus.done && sb.size() != 0) e = sb.pop_front();
    end
    check("held_no_double_done", dbl, 0);
    check("held_sb_drained", sb.size(), 0);
    scan_check(e);

    // each digit stays selected RD cycles, order 0,1,2,3 wrapping
    @(negedge clk);
    cur = sel_digit(bus.transistor);
    run = 1;
    first = 1'b1;
    repeat (16 * RD) begin
      @(negedge clk);
      d = sel_digit(bus.transistor);
      if (d == cur) run++;
      else begin
        if (!first) check("scan_run_len", run, RD);
        check("scan_order", d, (cur + 1) % 4);
        first = 1'b0;
        cur = d;
        run = 1;
      end
    end

    // reset during CONV aborts the computation and blanks immediately
    @(negedge clk);
    bus.a = tbl[1].a;
    bus.b = tbl[1].b;
    bus.sum_rest = tbl[1].op;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_abort_busy", {31'b0, bus.busy}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_transistor", {28'b0, bus.transistor}, 32'hF);
    check("abort_segm", {25'b0, bus.segm}, 32'h7F);
    check("abort_busy", {31'b0, bus.busy}, 0);
    check("abort_done", {31'b0, bus.done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (4 * RD + 4) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.transistor !== 4'hF || bus.segm !== 7'h7F) bad++;
    end
    check("abort_stays_blank", bad, 0);

    // start presented on the first edge after reset release is accepted
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse(tbl[2], 1'b0, tbl[2]);

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
